// File: rtl/ritc_cfglut_pkg.sv
// Shared types and constants for the RITC CFGLUT5 configuration loader.
package ritc_cfglut_pkg;

  localparam int LUT_BITS        = 32;
  localparam int LUTS_PER_SAMPLE = 3;

  // INIT words that make the corrector pass the 6-bit sample through unchanged
  localparam logic [31:0] DEF_HI  = 32'hF0F0CCCC;
  localparam logic [31:0] DEF_MID = 32'hAAAA0000;
  localparam logic [31:0] DEF_LO  = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SETUP,
    ST_STROBE,
    ST_FIN
  } state_t;

  // Power-up image: each sample owns three LUTs in HI, MID, LO order
  function automatic logic [31:0] def_word(input int k);
    case (k % LUTS_PER_SAMPLE)
      0:       def_word = DEF_HI;
      1:       def_word = DEF_MID;
      default: def_word = DEF_LO;
    endcase
  endfunction

endpackage

// File: rtl/ritc_cfglut_ram.sv
// Single-clock LUT image RAM: one write port, one registered read port.
// Contents come up holding the pass-through image and are never reset.
module ritc_cfglut_ram
  import ritc_cfglut_pkg::*;
#(
  parameter int WORDS = 144,
  parameter int AW    = 8
) (
  input  logic          sysclk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Power-up image, mapped to the block RAM initial contents
  initial begin
    for (int k = 0; k < WORDS; k++) mem[k] = def_word(k);
  end

  // Write port plus one-cycle registered read
  always_ff @(posedge sysclk_i) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ritc_cfglut_loader.sv
// CFGLUT5 image loader for the RITC dynamic INL corrector.
// Register bus access to the image in IDLE; on load the image is streamed
// MSB first, word WORDS-1 down to 0, with one clean CE rising edge per bit.
// Optional: RITC_CFGLUT_LOADER_CHECKSUM_EN builds a running XOR of streamed words.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | register access allowed, waiting for load_i
// ST_FETCH  | ptr presented to the RAM read port
// ST_LATCH  | fetched word captured into the shift register
// ST_SETUP  | ce low for HALF cycles, cdi carries the current bit
// ST_STROBE | ce high for HALF cycles, cdi held
// ST_FIN    | done pulse, outputs back to rest
module ritc_cfglut_loader
  import ritc_cfglut_pkg::*;
#(
  parameter int WORDS = 144,
  parameter int AW    = 8,
  parameter int HALF  = 4
) (
  input  logic          sysclk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          wr_i,
  input  logic          rd_i,
  output logic [31:0]   rdata_o,
  output logic          rvalid_o,
  input  logic          load_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cdi_o,
  output logic          ce_o,
  output logic [31:0]   checksum_o
);

  localparam int TW = $clog2(HALF) + 1;

  state_t              state, state_nxt;
  logic [AW-1:0]       ptr, ptr_nxt;
  logic [4:0]          bitcnt, bitcnt_nxt;
  logic [TW-1:0]       tmr, tmr_nxt;
  logic [LUT_BITS-1:0] shreg, shreg_nxt;
  logic [31:0]         ram_q;
  logic                cdi_nxt, ce_nxt, busy_nxt, done_nxt;
  logic                idle, addr_ok, tmr_done;
  logic                rd_p1, rd_ok_p1;

  assign idle     = (state == ST_IDLE);
  assign addr_ok  = (int'(addr_i) < WORDS);
  assign tmr_done = (tmr == '0);

  ritc_cfglut_ram #(.WORDS(WORDS), .AW(AW)) u_ram (
    .sysclk_i (sysclk_i),
    .we       (wr_i && idle && addr_ok),
    .waddr    (addr_i),
    .wdata    (wdata_i),
    .raddr    (idle ? addr_i : ptr),
    .rdata    (ram_q)
  );

  // State register
  always_ff @(posedge sysclk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (load_i) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_SETUP;
      ST_SETUP:  if (tmr_done) state_nxt = ST_STROBE;
      ST_STROBE: begin
        if (tmr_done) begin
          if (bitcnt != '0)   state_nxt = ST_SETUP;
          else if (ptr != '0) state_nxt = ST_FETCH;
          else                state_nxt = ST_FIN;
        end
      end
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered from these
  always_comb begin
    ptr_nxt    = ptr;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    tmr_nxt    = tmr_done ? tmr : tmr - 1'b1;
    if ((state_nxt != state) && (state_nxt == ST_SETUP || state_nxt == ST_STROBE))
      tmr_nxt = TW'(HALF - 1);
    case (state)
      ST_IDLE:   if (load_i) ptr_nxt = AW'(WORDS - 1);
      ST_LATCH: begin
        shreg_nxt  = ram_q;
        bitcnt_nxt = 5'(LUT_BITS - 1);
      end
      ST_STROBE: begin
        if (tmr_done) begin
          if (bitcnt != '0) begin
            shreg_nxt  = {shreg[LUT_BITS-2:0], 1'b0};
            bitcnt_nxt = bitcnt - 1'b1;
          end else if (ptr != '0) begin
            ptr_nxt = ptr - 1'b1;
          end
        end
      end
      default: ;
    endcase
    ce_nxt   = (state_nxt == ST_STROBE);
    done_nxt = (state_nxt == ST_FIN);
    busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FIN);
    // cdi only moves on SETUP entry; it parks at 0 outside a load
    case (state_nxt)
      ST_SETUP:                      cdi_nxt = shreg_nxt[LUT_BITS-1];
      ST_FETCH, ST_LATCH, ST_STROBE: cdi_nxt = cdi_o;
      default:                       cdi_nxt = 1'b0;
    endcase
  end

  // Streaming datapath and registered serial outputs
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      ptr    <= '0;
      bitcnt <= '0;
      tmr    <= '0;
      shreg  <= '0;
      cdi_o  <= 1'b0;
      ce_o   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      bitcnt <= bitcnt_nxt;
      tmr    <= tmr_nxt;
      shreg  <= shreg_nxt;
      cdi_o  <= cdi_nxt;
      ce_o   <= ce_nxt;
      busy_o <= busy_nxt;
      done_o <= done_nxt;
    end
  end

  // Register-bus readback pipeline and reject flag
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      rd_p1    <= 1'b0;
      rd_ok_p1 <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rd_p1    <= rd_i;
      rd_ok_p1 <= rd_i && idle && addr_ok;
      rvalid_o <= rd_p1;
      rdata_o  <= rd_ok_p1 ? ram_q : '0;
      err_o    <= (wr_i || rd_i) && !(idle && addr_ok);
    end
  end

`ifdef RITC_CFGLUT_LOADER_CHECKSUM_EN
  // Running XOR of every word latched for streaming
  always_ff @(posedge sysclk_i) begin
    if (rst_i)                 checksum_o <= '0;
    else if (idle && load_i)   checksum_o <= '0;
    else if (state == ST_LATCH) checksum_o <= checksum_o ^ ram_q;
  end
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_ritc_cfglut_loader.sv
// Self-checking bench for ritc_cfglut_loader.
module tb_ritc_cfglut_loader;
  import ritc_cfglut_pkg::*;

  localparam int WORDS    = 144;
  localparam int AW       = 8;
  localparam int HALF     = 4;
  localparam int LOAD_CYC = WORDS * (2 + 64 * HALF) + 1;
  localparam int NBITS    = WORDS * 32;

  logic          sysclk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic          wr_i = 1'b0, rd_i = 1'b0, load_i = 1'b0;
  logic [31:0]   rdata_o, checksum_o;
  logic          rvalid_o, busy_o, done_o, err_o, cdi_o, ce_o;

  always #5 sysclk_i = ~sysclk_i;

  ritc_cfglut_loader #(.WORDS(WORDS), .AW(AW), .HALF(HALF)) dut (
    .sysclk_i   (sysclk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wr_i       (wr_i),
    .rd_i       (rd_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .load_i     (load_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .cdi_o      (cdi_o),
    .ce_o       (ce_o),
    .checksum_o (checksum_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [WORDS];
  logic [31:0] rd_q [$];
  bit          bit_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_xor();
    logic [31:0] x = '0;
    for (int k = 0; k < WORDS; k++) x ^= model[k];
    return x;
  endfunction

  task automatic reg_write(input logic [AW-1:0] a, input logic [31:0] d);
    bit exp_err;
    exp_err = (int'(a) >= WORDS);
    @(negedge sysclk_i);
    addr_i = a; wdata_i = d; wr_i = 1'b1;
    if (!exp_err) model[a] = d;
    @(negedge sysclk_i);
    wr_i = 1'b0;
    chk("wr_err", {31'b0, err_o}, {31'b0, exp_err});
  endtask

  task automatic reg_read(input logic [AW-1:0] a);
    bit exp_err;
    exp_err = (int'(a) >= WORDS);
    rd_q.push_back(exp_err ? 32'h0 : model[a]);
    @(negedge sysclk_i);
    addr_i = a; rd_i = 1'b1;
    @(negedge sysclk_i);
    rd_i = 1'b0;
    chk("rd_err", {31'b0, err_o}, {31'b0, exp_err});
    chk("rd_early_valid", {31'b0, rvalid_o}, 32'h0);
    @(negedge sysclk_i);
    chk("rd_rvalid", {31'b0, rvalid_o}, 32'h1);
    chk("rd_data", rdata_o, rd_q.pop_front());
  endtask

  // Starts a load and monitors it; optional busy-time accesses, optional reset
  // at cycle rst_at, optional write issued in the same cycle as load_i.
  task automatic run_load(input bit busy_tests, input int rst_at, input bit with_wr,
                          input logic [AW-1:0] wa, input logic [31:0] wd,
                          input int seg_word, output int done_cyc, output int edges,
                          output int mism, output int viol, output logic [31:0] seg);
    bit   cap [$];
    logic prev_ce, prev_cdi;
    int   since, p, dones;
    done_cyc = 0; edges = 0; mism = 0; viol = 0; seg = '0;
    @(negedge sysclk_i);
    if (with_wr) begin
      addr_i = wa; wdata_i = wd; wr_i = 1'b1;
      model[wa] = wd;
    end
    for (int w = WORDS - 1; w >= 0; w--)
      for (int b = 31; b >= 0; b--) bit_q.push_back(model[w][b]);
    load_i = 1'b1;
    @(negedge sysclk_i);
    load_i = 1'b0; wr_i = 1'b0;
    prev_ce = 1'b0; prev_cdi = 1'b0; since = 0;
    for (int n = 1; n <= LOAD_CYC + 50; n++) begin
      if (n > 1) @(negedge sysclk_i);
      if (cdi_o !== prev_cdi) begin
        since = 0;
        if (ce_o) viol++;
      end else begin
        since++;
      end
      if (ce_o && !prev_ce) begin
        edges++;
        if (since < HALF) viol++;
        cap.push_back(cdi_o);
        if (bit_q.size() > 0) begin
          if (bit_q.pop_front() !== cdi_o) mism++;
        end else begin
          mism++;
        end
      end
      prev_ce = ce_o; prev_cdi = cdi_o;
      if (done_o) begin
        done_cyc = n;
        break;
      end
      if (rst_at != 0 && n == rst_at) begin
        rst_i = 1'b1;
        @(negedge sysclk_i);
        rst_i = 1'b0;
        chk("rst_ce", {31'b0, ce_o}, 32'h0);
        chk("rst_cdi", {31'b0, cdi_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        dones = 0;
        repeat (40) begin
          @(negedge sysclk_i);
          if (done_o) dones++;
        end
        chk("rst_no_done", dones, 0);
        bit_q.delete();
        return;
      end
      if (busy_tests) begin
        if (n == 2) chk("busy_on", {31'b0, busy_o}, 32'h1);
        if (n == 500) begin
          addr_i = '0; wdata_i = 32'hDEADBEEF; wr_i = 1'b1; load_i = 1'b1;
        end
        if (n == 501) begin
          wr_i = 1'b0; load_i = 1'b0;
          chk("busy_wr_err", {31'b0, err_o}, 32'h1);
        end
        if (n == 600) begin
          addr_i = 8'd7; rd_i = 1'b1;
        end
        if (n == 601) begin
          rd_i = 1'b0;
          chk("busy_rd_err", {31'b0, err_o}, 32'h1);
        end
        if (n == 602) begin
          chk("busy_rd_valid", {31'b0, rvalid_o}, 32'h1);
          chk("busy_rd_data", rdata_o, 32'h0);
        end
      end
    end
    p = (WORDS - 1 - seg_word) * 32;
    if (cap.size() >= p + 32)
      for (int i = 0; i < 32; i++) seg[31-i] = cap[p+i];
    if (bit_q.size() != 0) mism += bit_q.size();
    bit_q.delete();
  endtask

  initial begin
    int          dc, ed, mm, vi;
    logic [31:0] sg, exp_ck;
    for (int k = 0; k < WORDS; k++) model[k] = def_word(k);

    repeat (3) @(negedge sysclk_i);
    chk("reset_outputs", {rdata_o[15:0], 8'h0, rvalid_o, busy_o, done_o, err_o, cdi_o, ce_o, 2'b0},
        32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_checksum", checksum_o, 32'h0);
    rst_i = 1'b0;

    reg_read(8'd0);
    reg_read(8'd1);
    reg_read(8'd2);
    reg_read(8'd143);
    chk("pwr_word0_const", model[0], 32'hF0F0CCCC);

    reg_write(8'd200, 32'hCAFEF00D);
    reg_read(8'd200);
    reg_read(8'd56);

    reg_write(8'd5, 32'h12345678);
    reg_read(8'd5);

    run_load(1'b1, 0, 1'b0, '0, '0, 5, dc, ed, mm, vi, sg);
    chk("load1_done_cycle", dc, LOAD_CYC);
    chk("load1_edges", ed, NBITS);
    chk("load1_stream", mm, 0);
    chk("load1_cdi_timing", vi, 0);
    chk("load1_word5_seg", sg, 32'h12345678);
    @(negedge sysclk_i);
    chk("load1_idle", {30'b0, busy_o, done_o}, 32'h0);
`ifdef RITC_CFGLUT_LOADER_CHECKSUM_EN
    exp_ck = model_xor();
`else
    exp_ck = 32'h0;
`endif
    chk("load1_checksum", checksum_o, exp_ck);
    reg_read(8'd0);
    reg_read(8'd5);

    run_load(1'b0, 1000, 1'b0, '0, '0, 0, dc, ed, mm, vi, sg);

    reg_write(8'd5, 32'hFFFFFFFF);
    run_load(1'b0, 0, 1'b1, 8'd0, 32'h00000001, 0, dc, ed, mm, vi, sg);
    chk("load2_done_cycle", dc, LOAD_CYC);
    chk("load2_edges", ed, NBITS);
    chk("load2_stream", mm, 0);
    chk("load2_cdi_timing", vi, 0);
    chk("load2_word0_seg", sg, 32'h00000001);
`ifdef RITC_CFGLUT_LOADER_CHECKSUM_EN
    exp_ck = 32'hF0F0CCCD;
`else
    exp_ck = 32'h0;
`endif
    @(negedge sysclk_i);
    chk("load2_checksum", checksum_o, exp_ck);
    reg_read(8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ritc_cfglut_loader.md
Name: ritc_cfglut_loader

Overview:
- Sits directly upstream of the RITC dynamic INL corrector.
- Holds the complete CFGLUT5 configuration image for all channels in an inferred block RAM, written and read back 32 bits at a time over the register bus.
- On a load command it streams the image serially, MSB first, onto the corrector's CDI chain.
- Each configuration bit gets its own clean rising edge on CE, so the corrector's edge-detected CE fires exactly once per bit.

Parameters:
- WORDS, 144: number of 32-bit LUT words (3 channels x 16 samples x 3 LUTs).
- AW, 8: word address width; 2**AW must be at least WORDS.
- HALF, 4: sysclk cycles per CE phase (low, then high); minimum 4.

Ports:
- sysclk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- addr_i  in  AW  word address for register access
- wdata_i  in  32  write data
- wr_i  in  1  single-cycle write strobe
- rd_i  in  1  single-cycle read strobe
- rdata_o  out  32  readback data
- rvalid_o  out  1  readback valid pulse
- load_i  in  1  single-cycle start-load strobe
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse when a load completes
- err_o  out  1  one-cycle pulse when an access is rejected
- cdi_o  out  1  serial configuration data to the corrector
- ce_o  out  1  configuration enable to the corrector; one rising edge per bit
- checksum_o  out  32  running XOR of streamed words (optional feature)

Behaviour:
- Reset values: cdi_o=0, ce_o=0, busy_o=0, done_o=0, err_o=0, rvalid_o=0, rdata_o=0, checksum_o=0. The FSM returns to IDLE.
- RAM contents are not affected by reset.
- RAM power-up image: for s=0..47,
  - word 3s = F0F0CCCC
  - word 3s+1 = AAAA0000
  - word 3s+2 = FFFFFFFF
  - This image reproduces uncorrected 6-bit output.
- Word-to-LUT mapping: word k is the k-th LUT in chain order. Word 0 is nearest cdi_o (channel 0, sample 0, upper-bit LUT).
- Streaming order: addresses WORDS-1 down to 0, each word bit 31 first. Word 0 bit 0 is the last bit shifted.
- Register access in IDLE:
  - wr_i writes RAM[addr_i] in that cycle.
  - rd_i returns RAM[addr_i] on rdata_o with rvalid_o exactly 2 cycles later (one cycle RAM latency, one output register).
  - addr_i >= WORDS: the write is dropped, or the read returns 0 with rvalid_o; err_o pulses in either case.
- Register access while busy_o=1:
  - wr_i is dropped and err_o pulses.
  - rd_i returns rdata_o=0 with rvalid_o and err_o.
- Simultaneous load_i and wr_i in IDLE: the write commits first, then the load starts, so the new word is streamed.
- load_i while busy: ignored, no err.
- FSM states:
  - IDLE: on load_i, set ptr=WORDS-1, busy_o=1, go to FETCH.
  - FETCH (1 cycle): present ptr to the RAM read port.
  - LATCH (1 cycle): capture the word into a 32-bit shift register; bitcnt=31.
  - SETUP (HALF cycles): ce_o=0, cdi_o=shift[31].
  - STROBE (HALF cycles): ce_o=1, cdi_o held.
    - At the end, if bitcnt>0: shift left, bitcnt--, go to SETUP.
    - Else if ptr>0: ptr--, go to FETCH.
    - Else go to FIN.
  - FIN (1 cycle): ce_o=0, cdi_o=0, busy_o=0, done_o=1, go to IDLE.
- cdi_o changes only on SETUP entry, at least HALF cycles before and after each ce_o rising edge.
- Load length: WORDS*(2+64*HALF)+1 cycles from the cycle after load_i to done_o. With defaults: 37153.
- ce_o and cdi_o are registered outputs, with no glitches and no combinational paths from inputs.
- Reset mid-load: outputs go to reset values next cycle and done_o does not pulse. The LUT image is then partial; software must reload.

Optional Feature:
- Macro: RITC_CFGLUT_LOADER_CHECKSUM_EN.
- When defined:
  - checksum_o clears to 0 on load start.
  - Each LATCH XORs the fetched word into checksum_o.
  - The value is final when done_o pulses and holds until the next load or reset.
- When undefined: checksum_o is tied to 0 and no XOR logic is built.

Decomposition:
- Shared package ritc_cfglut_pkg holds:
  - the FSM state enum;
  - LUT_BITS=32 and LUTS_PER_SAMPLE=3;
  - the three default INIT constants (DEF_HI=F0F0CCCC, DEF_MID=AAAA0000, DEF_LO=FFFFFFFF).
- One sub-module, ritc_cfglut_ram: single-clock RAM, one write and one read port, 1-cycle registered read, default image loaded through an initial block built from the package constants.

Test Plan:
- Power-up: read words 0,1,2 and 143 -> F0F0CCCC, AAAA0000, FFFFFFFF, FFFFFFFF, each with rvalid_o 2 cycles after rd_i.
- Write word 5 = 12345678, then load. Capture cdi_o on each ce_o rising edge -> 4608 bits. The stream is word 143 first; word 5's segment equals 0x12345678 MSB first. done_o at cycle 37153; exactly 4608 ce_o rising edges.
- During a load: wr_i to word 0 -> err_o pulse and RAM unchanged. rd_i -> rdata_o=0, rvalid_o=1. A second load_i -> no effect on count or timing.
- Address 200: write -> err_o and no RAM change; read -> 0 with err_o.
- Assert rst_i at cycle 1000 of a load -> next cycle ce_o=0, cdi_o=0, busy_o=0; no done_o. A fresh load then completes normally.
- With RITC_CFGLUT_LOADER_CHECKSUM_EN: default image load -> checksum_o = XOR of 48 copies of each default word = 00000000. After writing word 0 = 00000001 -> F0F0CCCD.
